// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states and common command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    XFER,
    ACK,
    WAIT_IDLE,
    DONE,
    FAIL
  } ps2_tx_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-stage synchroniser for a raw PS/2 line plus a one-cycle falling-edge strobe.
module ps2_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_fe
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Idle bus level is high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync[0] <= i_async;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_fe   = r_prev & ~o_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out one
// byte plus odd parity and stop, then check the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_low,
  output logic       ps2_dat_low
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  ps2_tx_state_t          r_state, w_next;
  logic [INH_W-1:0]       r_inh_cnt;
  logic [TO_W-1:0]        r_to_cnt;
  logic [3:0]             r_bitcnt;
  logic [7:0]             r_shreg;
  logic                   r_par;
  logic                   r_dat_low;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   w_clk_s, w_fe, w_dat_s;
  logic                   w_timed, w_to_expire, w_inh_last;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (ps2_clk_i),
    .o_sync  (w_clk_s),
    .o_fe    (w_fe)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dat_sync <= '1;
    end else begin
      r_dat_sync[0] <= ps2_dat_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_dat_sync[i] <= r_dat_sync[i-1];
    end
  end
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

  assign w_timed    = (r_state == XFER) || (r_state == ACK) || (r_state == WAIT_IDLE);
  assign w_inh_last = (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
  // Counter is cleared in RTS (the cycle CLK is released); expiring one count
  // early lands the error pulse exactly TIMEOUT_CYCLES after that release.
  assign w_to_expire = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    tx_ready    = 1'b0;
    tx_done     = 1'b0;
    tx_error    = 1'b0;
    ps2_clk_low = 1'b0;
    ps2_dat_low = 1'b0;
    unique case (r_state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) w_next = INHIBIT;
      end
      INHIBIT: begin
        ps2_clk_low = 1'b1;
        if (w_inh_last) w_next = RTS;
      end
      RTS: begin
        ps2_dat_low = 1'b1;
        w_next      = XFER;
      end
      XFER: begin
        ps2_dat_low = r_dat_low;
        if (w_fe && (r_bitcnt == 4'd9)) w_next = ACK;
      end
      ACK: begin
        if (w_fe) w_next = w_dat_s ? FAIL : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (w_clk_s && w_dat_s) w_next = DONE;
      end
      DONE: begin
        tx_done = 1'b1;
        w_next  = IDLE;
      end
      FAIL: begin
        tx_error = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_timed && w_to_expire) w_next = FAIL;
  end

  assign busy = ~tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_bitcnt  <= '0;
      r_shreg   <= '0;
      r_par     <= 1'b0;
      r_dat_low <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_dat_low <= 1'b0;
          if (tx_valid) begin
            r_shreg   <= tx_data;
            r_par     <= odd_parity(tx_data);
            r_inh_cnt <= '0;
          end
        end
        INHIBIT: begin
          if (!w_inh_last) r_inh_cnt <= r_inh_cnt + 1'b1;
        end
        RTS: begin
          r_to_cnt  <= '0;
          r_bitcnt  <= '0;
          r_dat_low <= 1'b1;
        end
        XFER, ACK, WAIT_IDLE: begin
          if (r_to_cnt != TO_W'(TIMEOUT_CYCLES - 1)) r_to_cnt <= r_to_cnt + 1'b1;
          if ((r_state == XFER) && w_fe) begin
            if (r_bitcnt < 4'd8)       r_dat_low <= ~r_shreg[r_bitcnt[2:0]];
            else if (r_bitcnt == 4'd8) r_dat_low <= ~r_par;
            else                       r_dat_low <= 1'b0;
            if (r_bitcnt != 4'hF) r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        default: r_dat_low <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector bus and a PS/2 device model.
module tb_ps2_host_tx;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error, ps2_clk_low, ps2_dat_low;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       w_clk_line, w_dat_line;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;

  logic [10:0] dev_bits;
  int          dev_inh;
  int          dev_rts_cyc;
  logic        dev_tmo;

  assign w_clk_line = ~(ps2_clk_low | dev_clk_low);
  assign w_dat_line = ~(ps2_dat_low | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (20),
    .TIMEOUT_CYCLES (2000),
    .SYNC_STAGES    (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .ps2_clk_i   (w_clk_line),
    .ps2_dat_i   (w_dat_line),
    .ps2_clk_low (ps2_clk_low),
    .ps2_dat_low (ps2_dat_low)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done) n_done++;
    if (tx_error) n_err++;
    if (tx_done && tx_error) n_both++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Device: wait out inhibit, sample start, then give nclk clock pulses,
  // sampling DAT on each rising edge; pulse 11 carries the ACK if requested.
  task automatic dev_run(input int nclk, input logic ack);
    int k;
    dev_bits = '0;
    dev_inh  = 0;
    dev_tmo  = 1'b0;
    k = 0;
    while (!ps2_clk_low && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!ps2_clk_low) dev_tmo = 1'b1;
    while (ps2_clk_low && dev_inh < 500) begin
      dev_inh++;
      @(negedge clk);
    end
    dev_rts_cyc = cyc;
    repeat (HALF) @(negedge clk);
    dev_bits[0] = w_dat_line;
    for (int i = 1; i <= nclk; i++) begin
      if (i == 11 && ack) dev_dat_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i <= 10) dev_bits[i] = w_dat_line;
      repeat (HALF) @(negedge clk);
      if (i == 11) dev_dat_low = 1'b0;
    end
  endtask

  task automatic xfer(input string tag, input logic [7:0] d, input logic par, input logic ack);
    int d0, e0;
    d0 = n_done;
    e0 = n_err;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_run(11, ack);
    repeat (10) @(negedge clk);
    check_eq({tag, "_started"}, 32'(dev_tmo), 32'd0);
    check_eq({tag, "_frame"}, 32'(dev_bits), 32'({1'b1, par, d, 1'b0}));
    check_eq({tag, "_done"}, 32'(n_done - d0), ack ? 32'd1 : 32'd0);
    check_eq({tag, "_error"}, 32'(n_err - e0), ack ? 32'd0 : 32'd1);
    check_eq({tag, "_ready"}, 32'(tx_ready), 32'd1);
    check_eq({tag, "_lines"}, 32'({ps2_clk_low, ps2_dat_low}), 32'd0);
  endtask

  initial begin
    int d0, e0, k, err_cyc;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_pulses", 32'({tx_done, tx_error}), 32'd0);
    check_eq("rst_lines", 32'({ps2_clk_low, ps2_dat_low}), 32'd0);

    // ED: frame start 0, 1,0,1,1,0,1,1,1, parity 1, stop 1
    xfer("ed", 8'hED, 1'b1, 1'b1);
    check_eq("ed_inhibit_len", 32'(dev_inh), 32'd20);

    xfer("p00", 8'h00, 1'b1, 1'b1);
    xfer("pff", 8'hFF, 1'b1, 1'b1);
    xfer("p01", 8'h01, 1'b0, 1'b1);

    // No ACK from device
    xfer("nack", 8'hA5, 1'b1, 1'b0);

    // Device never clocks after RTS
    e0 = n_err;
    d0 = n_done;
    @(negedge clk);
    tx_data  = 8'hF4;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_run(0, 1'b0);
    check_eq("tmo_start_bit", 32'(dev_bits[0]), 32'd0);
    k = 0;
    while (!tx_error && k < 3000) begin
      @(negedge clk);
      k++;
    end
    err_cyc = cyc;
    check_eq("tmo_latency", 32'(err_cyc - dev_rts_cyc), 32'd2000);
    check_eq("tmo_lines_at_err", 32'({ps2_clk_low, ps2_dat_low}), 32'd0);
    @(negedge clk);
    check_eq("tmo_ready_next", 32'(tx_ready), 32'd1);
    check_eq("tmo_err_count", 32'(n_err - e0), 32'd1);
    check_eq("tmo_no_done", 32'(n_done - d0), 32'd0);

    // tx_valid held with F4 while FF is being sent
    d0 = n_done;
    @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hF4;
    dev_run(11, 1'b1);
    check_eq("hold_first_frame", 32'(dev_bits), 32'({1'b1, 1'b1, 8'hFF, 1'b0}));
    k = 0;
    while (!ps2_clk_low && k < 200) begin
      @(negedge clk);
      k++;
    end
    tx_valid = 1'b0;
    check_eq("hold_first_done", 32'(n_done - d0), 32'd1);
    dev_run(11, 1'b1);
    repeat (10) @(negedge clk);
    check_eq("hold_second_frame", 32'(dev_bits), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
    check_eq("hold_done_total", 32'(n_done - d0), 32'd2);
    check_eq("hold_ready", 32'(tx_ready), 32'd1);

    // Reset after the 4th falling edge of ED
    @(negedge clk);
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_run(3, 1'b0);
    dev_clk_low = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("rst4_busy_before", 32'(busy), 32'd1);
    d0 = n_done;
    e0 = n_err;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst4_lines", 32'({ps2_clk_low, ps2_dat_low}), 32'd0);
    check_eq("rst4_ready", 32'(tx_ready), 32'd1);
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("rst4_no_pulse", 32'((n_done - d0) + (n_err - e0)), 32'd0);
    check_eq("rst4_idle_lines", 32'({ps2_clk_low, ps2_dat_low}), 32'd0);

    check_eq("never_both_pulses", 32'(n_both), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
